// File: rtl/decode_pkg.sv
// Shared opcode and control-field definitions for the ID stage with hazard detection.
package decode_pkg;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    localparam int WB_W  = 2;
    localparam int MEM_W = 3;
    localparam int EX_W  = 4;

    localparam int MEM_READ_BIT    = 1;
    localparam int WB_REGWRITE_BIT = 1;

    typedef struct packed {
        logic [WB_W-1:0]  wb;   // {regwrite, memtoreg}
        logic [MEM_W-1:0] mem;  // {branch, memread, memwrite}
        logic [EX_W-1:0]  ex;   // {regdst, aluop[1:0], alusrc}
    } ctrl_t;

    localparam ctrl_t CTRL_NONE  = '{wb: 2'b00, mem: 3'b000, ex: 4'b0000};
    localparam ctrl_t CTRL_RTYPE = '{wb: 2'b10, mem: 3'b000, ex: 4'b1100};
    localparam ctrl_t CTRL_LW    = '{wb: 2'b11, mem: 3'b010, ex: 4'b0001};
    localparam ctrl_t CTRL_SW    = '{wb: 2'b00, mem: 3'b001, ex: 4'b0001};
    localparam ctrl_t CTRL_BEQ   = '{wb: 2'b00, mem: 3'b100, ex: 4'b0010};

    function automatic ctrl_t decode_ctrl(input logic [5:0] op);
        case (op)
            OP_RTYPE: decode_ctrl = CTRL_RTYPE;
            OP_LW:    decode_ctrl = CTRL_LW;
            OP_SW:    decode_ctrl = CTRL_SW;
            OP_BEQ:   decode_ctrl = CTRL_BEQ;
            default:  decode_ctrl = CTRL_NONE;
        endcase
    endfunction
endpackage

// File: rtl/regfile_bypass.sv
// Two-read, one-write register file; a same-cycle write is forwarded to the reads.
module regfile_bypass #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    localparam int RA_W = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we_i,
    input  logic [RA_W-1:0] waddr_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [RA_W-1:0] raddr1_i,
    input  logic [RA_W-1:0] raddr2_i,
    output logic [XLEN-1:0] rdata1_o,
    output logic [XLEN-1:0] rdata2_o
);
    logic [XLEN-1:0] regs_q [NREGS];
    logic            wr_en;

    assign wr_en = we_i && (waddr_i != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else if (wr_en) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        rdata1_o = regs_q[raddr1_i];
        rdata2_o = regs_q[raddr2_i];
        if (raddr1_i == '0)                    rdata1_o = '0;
        else if (wr_en && raddr1_i == waddr_i) rdata1_o = wdata_i;
        if (raddr2_i == '0)                    rdata2_o = '0;
        else if (wr_en && raddr2_i == waddr_i) rdata2_o = wdata_i;
    end
endmodule

// File: rtl/decode_hz.sv
// MIPS ID stage: control decode, register read, load-use stall/bubble, ID/EX latch
// and a saturating stall-cycle counter.
module decode_hz
    import decode_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int CNT_W = 16,
    localparam int RA_W = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_reg_write,
    input  logic [RA_W-1:0]   wb_write_reg_location,
    input  logic [XLEN-1:0]   mem_wb_write_data,
    input  logic [31:0]       if_id_instr,
    input  logic [XLEN-1:0]   if_id_npc,
    input  logic              if_id_valid,
    input  logic              ex_flush,
    output logic              stall,
    output logic              id_ex_valid,
    output logic [WB_W-1:0]   id_ex_wb,
    output logic [MEM_W-1:0]  id_ex_mem,
    output logic [EX_W-1:0]   id_ex_execute,
    output logic [XLEN-1:0]   id_ex_npc,
    output logic [XLEN-1:0]   id_ex_readdat1,
    output logic [XLEN-1:0]   id_ex_readdat2,
    output logic [XLEN-1:0]   id_ex_sign_ext,
    output logic [RA_W-1:0]   id_ex_instr_bits_20_16,
    output logic [RA_W-1:0]   id_ex_instr_bits_15_11,
    output logic [CNT_W-1:0]  stall_count
);
    logic [RA_W-1:0]  rs, rt, rd;
    logic [XLEN-1:0]  rdat1, rdat2, sext;
    ctrl_t            ctrl_dec;
    logic             hz;

    logic             valid_q, valid_d;
    ctrl_t            ctrl_q, ctrl_d;
    logic [XLEN-1:0]  npc_q, rd1_q, rd2_q, sext_q;
    logic [RA_W-1:0]  rt_q, rd_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign rs       = RA_W'(if_id_instr[25:21]);
    assign rt       = RA_W'(if_id_instr[20:16]);
    assign rd       = RA_W'(if_id_instr[15:11]);
    assign sext     = {{(XLEN-16){if_id_instr[15]}}, if_id_instr[15:0]};
    assign ctrl_dec = decode_ctrl(if_id_instr[31:26]);

    regfile_bypass #(.XLEN(XLEN), .NREGS(NREGS)) u_rf (
        .clk      (clk),
        .rst      (rst),
        .we_i     (wb_reg_write),
        .waddr_i  (wb_write_reg_location),
        .wdata_i  (mem_wb_write_data),
        .raddr1_i (rs),
        .raddr2_i (rt),
        .rdata1_o (rdat1),
        .rdata2_o (rdat2)
    );

    // A load in EX whose destination feeds the instruction in ID cannot be forwarded in time.
    assign hz = valid_q && ctrl_q.mem[MEM_READ_BIT] && (rt_q != '0)
             && ((rt_q == rs) || (rt_q == rt)) && if_id_valid;
    assign stall = hz && !ex_flush;

    always_comb begin
        valid_d = if_id_valid;
        ctrl_d  = if_id_valid ? ctrl_dec : CTRL_NONE;
        if (ex_flush || hz) begin
            valid_d = 1'b0;
            ctrl_d  = CTRL_NONE;
        end
        cnt_d = cnt_q;
        if (stall && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            ctrl_q  <= CTRL_NONE;
            npc_q   <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            sext_q  <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            npc_q   <= if_id_npc;
            rd1_q   <= rdat1;
            rd2_q   <= rdat2;
            sext_q  <= sext;
            rt_q    <= rt;
            rd_q    <= rd;
            cnt_q   <= cnt_d;
        end
    end

    assign id_ex_valid            = valid_q;
    assign id_ex_wb               = ctrl_q.wb;
    assign id_ex_mem              = ctrl_q.mem;
    assign id_ex_execute          = ctrl_q.ex;
    assign id_ex_npc              = npc_q;
    assign id_ex_readdat1         = rd1_q;
    assign id_ex_readdat2         = rd2_q;
    assign id_ex_sign_ext         = sext_q;
    assign id_ex_instr_bits_20_16 = rt_q;
    assign id_ex_instr_bits_15_11 = rd_q;
    assign stall_count            = cnt_q;
endmodule

// File: tb/tb_decode_hz.sv
// Scoreboard bench for decode_hz: the driver queues the expected ID/EX contents for
// each cycle and a monitor compares them after every rising edge.
module tb_decode_hz;
    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int CNT_W = 2;
    localparam int RA_W  = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             wb_reg_write;
    logic [RA_W-1:0]  wb_write_reg_location;
    logic [XLEN-1:0]  mem_wb_write_data;
    logic [31:0]      if_id_instr;
    logic [XLEN-1:0]  if_id_npc;
    logic             if_id_valid;
    logic             ex_flush;
    logic             stall;
    logic             id_ex_valid;
    logic [1:0]       id_ex_wb;
    logic [2:0]       id_ex_mem;
    logic [3:0]       id_ex_execute;
    logic [XLEN-1:0]  id_ex_npc, id_ex_readdat1, id_ex_readdat2, id_ex_sign_ext;
    logic [RA_W-1:0]  id_ex_instr_bits_20_16, id_ex_instr_bits_15_11;
    logic [CNT_W-1:0] stall_count;

    decode_hz #(.XLEN(XLEN), .NREGS(NREGS), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .wb_reg_write(wb_reg_write), .wb_write_reg_location(wb_write_reg_location),
        .mem_wb_write_data(mem_wb_write_data),
        .if_id_instr(if_id_instr), .if_id_npc(if_id_npc), .if_id_valid(if_id_valid),
        .ex_flush(ex_flush), .stall(stall),
        .id_ex_valid(id_ex_valid), .id_ex_wb(id_ex_wb), .id_ex_mem(id_ex_mem),
        .id_ex_execute(id_ex_execute), .id_ex_npc(id_ex_npc),
        .id_ex_readdat1(id_ex_readdat1), .id_ex_readdat2(id_ex_readdat2),
        .id_ex_sign_ext(id_ex_sign_ext),
        .id_ex_instr_bits_20_16(id_ex_instr_bits_20_16),
        .id_ex_instr_bits_15_11(id_ex_instr_bits_15_11),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic        valid;
        logic [1:0]  wb;
        logic [2:0]  mem;
        logic [3:0]  ex;
        logic [31:0] npc, rd1, rd2, se;
        logic [4:0]  rt, rd;
        logic [1:0]  cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input int rs, input int rt,
                                       input logic [15:0] imm);
        logic [4:0] s, t;
        s = 5'(rs);
        t = 5'(rt);
        return {op, s, t, imm};
    endfunction

    function automatic exp_t mkexp(input string tag, input logic v, input logic [1:0] wb,
                                   input logic [2:0] mem, input logic [3:0] ex,
                                   input logic [31:0] npc, input logic [31:0] rd1,
                                   input logic [31:0] rd2, input logic [31:0] se,
                                   input logic [4:0] rt, input logic [4:0] rd,
                                   input logic [1:0] cnt);
        exp_t e;
        e.tag = tag; e.valid = v; e.wb = wb; e.mem = mem; e.ex = ex;
        e.npc = npc; e.rd1 = rd1; e.rd2 = rd2; e.se = se; e.rt = rt; e.rd = rd; e.cnt = cnt;
        return e;
    endfunction

    // Drive one cycle's inputs on the falling edge, check the combinational stall,
    // then queue what ID/EX must hold after the next rising edge.
    task automatic step(input logic r, input logic v, input logic [31:0] instr,
                        input logic [31:0] npc, input logic fl, input logic we,
                        input logic [4:0] wloc, input logic [31:0] wdat,
                        input logic exp_stall, input exp_t e);
        @(negedge clk);
        rst = r; if_id_valid = v; if_id_instr = instr; if_id_npc = npc; ex_flush = fl;
        wb_reg_write = we; wb_write_reg_location = wloc; mem_wb_write_data = wdat;
        #1;
        cmp({e.tag, ".stall"}, 32'(stall), 32'(exp_stall));
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cmp({e.tag, ".valid"}, 32'(id_ex_valid), 32'(e.valid));
                cmp({e.tag, ".wb"},    32'(id_ex_wb),    32'(e.wb));
                cmp({e.tag, ".mem"},   32'(id_ex_mem),   32'(e.mem));
                cmp({e.tag, ".ex"},    32'(id_ex_execute), 32'(e.ex));
                cmp({e.tag, ".npc"},   id_ex_npc,      e.npc);
                cmp({e.tag, ".rd1"},   id_ex_readdat1, e.rd1);
                cmp({e.tag, ".rd2"},   id_ex_readdat2, e.rd2);
                cmp({e.tag, ".sext"},  id_ex_sign_ext, e.se);
                cmp({e.tag, ".rt"},    32'(id_ex_instr_bits_20_16), 32'(e.rt));
                cmp({e.tag, ".rd"},    32'(id_ex_instr_bits_15_11), 32'(e.rd));
                cmp({e.tag, ".cnt"},   32'(stall_count), 32'(e.cnt));
            end
        end
    end

    initial begin : driver
        logic [31:0] lw_r2, add_r3, lw_r0, use_r0, rr;
        logic [1:0]  c;
        int          budget;
        lw_r2  = mk(6'b100011, 1, 2, 16'h0000);   // lw r2,0(r1)
        add_r3 = mk(6'b000000, 2, 4, 16'h1820);   // add r3,r2,r4
        lw_r0  = mk(6'b100011, 1, 0, 16'h0004);   // lw r0,4(r1)
        use_r0 = mk(6'b000000, 0, 0, 16'h0000);

        rst = 1'b1; if_id_valid = 1'b0; if_id_instr = '0; if_id_npc = '0; ex_flush = 1'b0;
        wb_reg_write = 1'b0; wb_write_reg_location = '0; mem_wb_write_data = '0;

        // Reset held two cycles with garbage on the inputs; everything must stay zero.
        for (int i = 0; i < 2; i++)
            step(1, 1, add_r3, 32'h40, 0, 1, 5'd7, 32'h55, 0,
                 mkexp("reset", 0, 2'b00, 3'b000, 4'b0000, 0, 0, 0, 0, 0, 0, 0));

        // Every register reads zero after reset.
        for (int i = 0; i < 32; i++) begin
            rr = mk(6'b000000, i, 31 - i, 16'h0000);
            step(0, 1, rr, 32'h100 + i, 0, 0, 0, 0, 0,
                 mkexp("regzero", 1, 2'b10, 3'b000, 4'b1100, 32'h100 + i, 0, 0, 0,
                       5'(31 - i), 0, 0));
        end

        // Write-through of r5, then a write to r0 that must be ignored.
        step(0, 1, mk(6'b000000, 5, 0, 16'h0000), 32'h200, 0, 1, 5'd5, 32'hDEADBEEF, 0,
             mkexp("wthru", 1, 2'b10, 3'b000, 4'b1100, 32'h200, 32'hDEADBEEF, 0, 0, 0, 0, 0));
        step(0, 1, mk(6'b000000, 0, 5, 16'h0000), 32'h204, 0, 1, 5'd0, 32'h12345678, 0,
             mkexp("r0wr", 1, 2'b10, 3'b000, 4'b1100, 32'h204, 0, 32'hDEADBEEF, 0, 5, 0, 0));
        step(0, 1, mk(6'b000000, 0, 5, 16'h0000), 32'h208, 0, 0, 0, 0, 0,
             mkexp("r0rd", 1, 2'b10, 3'b000, 4'b1100, 32'h208, 0, 32'hDEADBEEF, 0, 5, 0, 0));

        // Load-use: one stall, one bubble, then the add issues.
        step(0, 1, lw_r2, 32'h300, 0, 0, 0, 0, 0,
             mkexp("lw", 1, 2'b11, 3'b010, 4'b0001, 32'h300, 0, 0, 0, 2, 0, 0));
        step(0, 1, add_r3, 32'h304, 0, 0, 0, 0, 1,
             mkexp("bubble", 0, 2'b00, 3'b000, 4'b0000, 32'h304, 0, 0, 32'h1820, 4, 3, 1));
        step(0, 1, add_r3, 32'h304, 0, 0, 0, 0, 0,
             mkexp("add", 1, 2'b10, 3'b000, 4'b1100, 32'h304, 0, 0, 32'h1820, 4, 3, 1));

        // A load into r0 never creates a hazard.
        step(0, 1, lw_r0, 32'h400, 0, 0, 0, 0, 0,
             mkexp("lwr0", 1, 2'b11, 3'b010, 4'b0001, 32'h400, 0, 0, 4, 0, 0, 1));
        step(0, 1, use_r0, 32'h404, 0, 0, 0, 0, 0,
             mkexp("user0", 1, 2'b10, 3'b000, 4'b1100, 32'h404, 0, 0, 0, 0, 0, 1));

        // Flush wins over the hazard.
        step(0, 1, lw_r2, 32'h500, 0, 0, 0, 0, 0,
             mkexp("lw2", 1, 2'b11, 3'b010, 4'b0001, 32'h500, 0, 0, 0, 2, 0, 1));
        step(0, 1, add_r3, 32'h504, 1, 0, 0, 0, 0,
             mkexp("flush", 0, 2'b00, 3'b000, 4'b0000, 32'h504, 0, 0, 32'h1820, 4, 3, 1));

        // Invalid IF/ID slot yields zero control.
        step(0, 0, add_r3, 32'h508, 0, 0, 0, 0, 0,
             mkexp("novalid", 0, 2'b00, 3'b000, 4'b0000, 32'h508, 0, 0, 32'h1820, 4, 3, 1));

        // Five more load-use stalls: the 2-bit counter saturates at 3.
        c = 2'd1;
        for (int k = 0; k < 5; k++) begin
            step(0, 1, lw_r2, 32'h600, 0, 0, 0, 0, 0,
                 mkexp("satlw", 1, 2'b11, 3'b010, 4'b0001, 32'h600, 0, 0, 0, 2, 0, c));
            if (c != 2'd3) c = c + 2'd1;
            step(0, 1, add_r3, 32'h604, 0, 0, 0, 0, 1,
                 mkexp("satst", 0, 2'b00, 3'b000, 4'b0000, 32'h604, 0, 0, 32'h1820, 4, 3, c));
        end

        // Reset while the hazard is present; stall is gone the following cycle.
        step(0, 1, lw_r2, 32'h700, 0, 0, 0, 0, 0,
             mkexp("rlw", 1, 2'b11, 3'b010, 4'b0001, 32'h700, 0, 0, 0, 2, 0, 3));
        step(1, 1, add_r3, 32'h704, 0, 0, 0, 0, 1,
             mkexp("rmid", 0, 2'b00, 3'b000, 4'b0000, 0, 0, 0, 0, 0, 0, 0));
        step(0, 1, add_r3, 32'h704, 0, 0, 0, 0, 0,
             mkexp("rpost", 1, 2'b10, 3'b000, 4'b1100, 32'h704, 0, 0, 32'h1820, 4, 3, 0));

        budget = 20;
        while (exp_q.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/decode_hz.md
# decode_hz

Parametrised successor ID stage for the 5-stage MIPS pipeline. It decodes the IF/ID instruction, reads a write-through register file, and detects load-use hazards. On a hazard it stalls IF and inserts a bubble. It also accepts a flush from the branch-resolution stage and registers everything into the ID/EX latch. The block sits between the IF/ID latch and the execute stage, and adds valid tracking and a saturating stall counter.

## Interface
Parameters:
- XLEN, 32, datapath width (register file, NPC, sign-extended immediate)
- NREGS, 32, register count; address width RA_W = $clog2(NREGS)
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- wb_reg_write  in  1  WB write enable
- wb_write_reg_location  in  RA_W  WB destination register
- mem_wb_write_data  in  XLEN  WB write data
- if_id_instr  in  32  instruction from IF/ID
- if_id_npc  in  XLEN  NPC from IF/ID
- if_id_valid  in  1  IF/ID holds a real instruction
- ex_flush  in  1  branch taken; kill the instruction in ID
- stall  out  1  combinational; hold PC and IF/ID this cycle
- id_ex_valid  out  1  ID/EX holds a real instruction
- id_ex_wb  out  2  {regwrite, memtoreg}
- id_ex_mem  out  3  {branch, memread, memwrite}
- id_ex_execute  out  4  {regdst, aluop[1:0], alusrc}
- id_ex_npc, id_ex_readdat1, id_ex_readdat2, id_ex_sign_ext  out  XLEN  latched data
- id_ex_instr_bits_20_16, id_ex_instr_bits_15_11  out  RA_W  rt, rd fields
- stall_count  out  CNT_W  saturating count of stall cycles

## Operation
- Opcode encodings (wb/mem/ex):
  - R-type 000000: 10/000/1100
  - lw 100011: 11/010/0001
  - sw 101011: 00/001/0001
  - beq 000100: 00/100/0010
  - any other opcode: all zero
- Sign extension: replicate instr[15] to XLEN.
- Register file:
  - Writes when wb_reg_write and the address is nonzero; register 0 always reads 0.
  - Write-through: if a read address equals wb_write_reg_location, the write is enabled and the address is nonzero, the read returns mem_wb_write_data in the same cycle.
- Load-use hazard condition: hz = id_ex_valid & id_ex_mem[1] & (id_ex_instr_bits_20_16 != 0) & (id_ex_instr_bits_20_16 == rs | id_ex_instr_bits_20_16 == rt) & if_id_valid.
- stall = hz & ~ex_flush. Flush has priority because the instruction being decoded is dead anyway.
- ID/EX update priority, every cycle:
  1. rst: all outputs 0.
  2. ex_flush or hz: load a bubble. Valid and wb/mem/ex are cleared; data fields still load from the current inputs.
  3. Otherwise load the decode results. id_ex_valid = if_id_valid; control fields are forced to zero when if_id_valid = 0.
- stall_count increments when stall = 1 and saturates at all-ones. It clears only on rst.

## Timing
- ID/EX outputs are registered with 1-cycle latency from IF/ID inputs.
- stall is purely combinational from the current ID/EX registers and if_id_instr. It has no registered delay.
- A load-use pair produces exactly one stall cycle. The next cycle the load sits in MEM, so hz deasserts.
- A register-file write and a same-cycle read of the same register resolve via write-through. No WB→ID hazard exists.
- Reset mid-stall: stall drops the cycle after rst is sampled, since id_ex_valid = 0.
- Reset values of all outputs are 0, including stall_count and every register-file entry.

## Structure
- Package decode_pkg holds:
  - opcode localparams (OP_RTYPE, OP_LW, OP_SW, OP_BEQ)
  - control field widths (WB_W=2, MEM_W=3, EX_W=4)
  - the encoding constants listed above
  - the bit-index names MEM_READ_BIT=1, WB_REGWRITE_BIT=1
- Sub-module regfile_bypass(XLEN, NREGS) contains the register file with write-through.
- Control decode, hazard logic, ID/EX latch and the counter live in the top level.

## Test plan
- Reset: assert rst for 2 cycles. Every output reads 0, and reading r0–r31 returns 0.
- Write-through: WB writes r5=0xDEADBEEF while if_id_instr reads rs=5. The next cycle id_ex_readdat1=0xDEADBEEF. A write to r0 leaves r0 reading 0.
- Load-use:
  - Stimulus: lw r2,0(r1), then add r3,r2,r4.
  - stall=1 for exactly one cycle, and a bubble follows the lw (id_ex_valid=0, id_ex_wb=00).
  - The add then issues with id_ex_execute=1100, and stall_count=1.
- lw with rt=0 followed by a use of r0: no stall.
- Flush: ex_flush=1 together with the hz condition gives stall=0, and the next cycle id_ex_valid=0 with zero control.
- Saturation: hold the hazard with CNT_W=2 for 5 stall cycles. stall_count reads 3.
